// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the state encoding and the default operand width.
// No logic lives here.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell, purely combinational.
// Latency: zero cycles.
// No handshake; the inputs are consumed as presented.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic sum,
  output logic Cout
);

  logic p;

  assign p    = A ^ B;
  assign sum  = p ^ Cin;
  assign Cout = (A & B) | (Cin & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared fulladder cell walks LSB to MSB over WIDTH cycles.
// Latency: done rises WIDTH cycles after start is sampled; one result per WIDTH+1 cycles.
// start is honoured only in IDLE or DONE; it is ignored while busy.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic             take;
  logic [WIDTH-1:0] s_next;

  fulladder u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .sum  (fa_s),
    .Cout (fa_co)
  );

  assign take   = start && ((state == IDLE) || (state == DONE));
  // The newest bit enters at the top so after WIDTH shifts bit 0 sits at the LSB.
  assign s_next = {fa_s, s_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (take) begin
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_next;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= s_next;
            cout  <= fa_co;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0, done_cnt16 = 0;
  int pushed8 = 0, pushed16 = 0;
  logic [32:0] q8[$];
  logic [32:0] q16[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit unsigned sum.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
    return 33'(x) + 33'(y) + 33'(c);
  endfunction

  // Monitors: pop the oldest expectation whenever a result is presented.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done8) begin
        done_cnt8++;
        if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          chk("result8", 64'({cout8, sum8}), 64'(e[8:0]));
        end
      end
    end
  end

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && done16) begin
        done_cnt16++;
        if (q16.size() == 0) chk("unexpected_done16", 64'd1, 64'd0);
        else begin
          e = q16.pop_front();
          chk("result16", 64'({cout16, sum16}), 64'(e[16:0]));
        end
      end
    end
  end

  // Present operands at the current negedge; the next posedge samples them.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c, input bit push);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    if (push) begin
      q8.push_back(ref_add(32'(x), 32'(y), c));
      pushed8++;
    end
  endtask

  // Counts negedges until done; done at lat==9 means WIDTH cycles after the sample edge.
  task automatic wait8(input bit hold, input bit scramble, input int pulse_at,
                       output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == pulse_at) begin
        start8 = 1'b1; a8 = 8'hAA;
      end else if (!hold) start8 = 1'b0;
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      if (busy8) busy_cnt++;
    end while (!done8 && lat < 40);
    if (!done8) chk("timeout8", 64'd1, 64'd0);
  endtask

  task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic c);
    a16 = x; b16 = y; cin16 = c; start16 = 1'b1;
    q16.push_back(ref_add(32'(x), 32'(y), c));
    pushed16++;
  endtask

  task automatic wait16(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    end while (!done16 && lat < 60);
    if (!done16) chk("timeout16", 64'd1, 64'd0);
  endtask

  initial begin
    int lat, bc, d0;

    repeat (3) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_sum8", 64'({cout8, sum8}), 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_sum16", 64'({cout16, sum16}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with timing.
    issue8(8'h5A, 8'h3C, 1'b0, 1'b1);
    wait8(1'b0, 1'b1, 0, lat, bc);
    chk("basic_latency", 64'(lat), 64'd9);
    chk("basic_busy_cycles", 64'(bc), 64'd8);
    @(negedge clk);
    chk("done_one_cycle", 64'(done8), 64'd0);
    chk("sum_held", 64'({cout8, sum8}), 64'h096);

    // Carry ripple cases.
    issue8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait8(1'b0, 1'b1, 0, lat, bc);
    @(negedge clk);
    issue8(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait8(1'b0, 1'b1, 0, lat, bc);
    @(negedge clk);

    // start during RUN must be ignored.
    d0 = done_cnt8;
    issue8(8'h10, 8'h20, 1'b0, 1'b1);
    wait8(1'b0, 1'b0, 4, lat, bc);
    chk("ignored_start_latency", 64'(lat), 64'd9);
    repeat (3) @(negedge clk);
    chk("ignored_start_done_count", 64'(done_cnt8 - d0), 64'd1);

    // Back-to-back with start held high.
    issue8(8'h01, 8'h01, 1'b0, 1'b1);
    wait8(1'b1, 1'b0, 0, lat, bc);
    issue8(8'h80, 8'h80, 1'b0, 1'b1);
    wait8(1'b1, 1'b0, 0, lat, bc);
    chk("b2b_spacing", 64'(lat), 64'd9);
    start8 = 1'b0;
    @(negedge clk);
    chk("b2b_stopped", 64'(done8), 64'd0);
    repeat (2) @(negedge clk);

    // Reset mid-operation.
    d0 = done_cnt8;
    issue8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_sum", 64'({cout8, sum8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt8 - d0), 64'd0);
    issue8(8'h33, 8'h44, 1'b0, 1'b1);
    wait8(1'b0, 1'b0, 0, lat, bc);
    @(negedge clk);

    // Random traffic on both widths in parallel.
    fork
      begin
        int l8, b8c;
        for (int i = 0; i < 200; i++) begin
          issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
          wait8(1'b0, 1'b1, 0, l8, b8c);
          if (i % 50 == 0) chk("rand8_latency", 64'(l8), 64'd9);
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
      end
      begin
        int l16;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          issue16(16'($urandom), 16'($urandom), 1'($urandom));
          wait16(l16);
          if (i % 50 == 0) chk("rand16_latency", 64'(l16), 64'd17);
        end
      end
    join

    repeat (3) @(negedge clk);
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);
    chk("done_count8", 64'(done_cnt8), 64'(pushed8));
    chk("done_count16", 64'(done_cnt16), 64'(pushed16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. It sequences a single 1-bit `fulladder` instance over WIDTH clock cycles to add two WIDTH-bit operands, using a start/done handshake. The block sits between a requester that supplies operands and the shared 1-bit adder cell, trading latency for area. It owns operand shifting, carry storage, bit counting and result capture.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request pulse; sampled only when the block is ready (IDLE or DONE).
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `cin`  in  1  carry-in; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; high while in DONE.
- `sum`  out  WIDTH  result register; valid from the `done` cycle and held until the next completion.
- `cout`  out  1  final carry; same validity as `sum`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DONE when bit counter == WIDTH-1.
  - DONE -> RUN on `start`; otherwise DONE -> IDLE.
- Accepting `start` (IDLE or DONE):
  - Load shift registers `a_sh` <= `a` and `b_sh` <= `b`.
  - Load carry register <= `cin`.
  - Clear bit counter to 0.
- Each RUN cycle:
  - The `fulladder` receives `a_sh[0]`, `b_sh[0]` and the carry register.
  - Its sum bit shifts into the MSB of `s_sh`, and `s_sh` shifts right.
  - `a_sh` and `b_sh` shift right.
  - Carry register <= adder carry-out.
  - Counter increments.
- On the RUN -> DONE edge:
  - `sum` <= final `s_sh` value, including the bit computed that cycle.
  - `cout` <= final carry-out.
  - `sum` and `cout` are not otherwise written.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, computed as (WIDTH+1)-bit unsigned. No overflow flag.
- Counter width is $clog2(WIDTH).
- Boundary conditions:
  - `start` during RUN is ignored, and the operands in flight are unaffected.
  - `start` held high continuously: a new operation is accepted in every DONE cycle, so operations run back-to-back.
  - `a`, `b` and `cin` changing during RUN have no effect.
  - `rst_n` low at any time, including mid-RUN, immediately forces the reset state below. A partial result is discarded and never appears on `sum`.
- Reset values:
  - State = IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - Shift registers, carry register and counter = 0.

## Timing
- `start` is sampled at edge k.
- RUN occupies edges k+1 .. k+WIDTH; `busy` is high from after edge k until after edge k+WIDTH.
- `done` is high for exactly one cycle, between edges k+WIDTH and k+WIDTH+1.
- `sum` and `cout` change only at edge k+WIDTH.
- Latency from `start` sample to `done` high: WIDTH cycles.
- Throughput with back-to-back requests: one result per WIDTH+1 cycles.
- `busy`, `done`, `sum` and `cout` are all registered; there is no combinational path from inputs to outputs.
- The `fulladder` path is purely combinational within one cycle.

## Structure
- Package `serial_adder_pkg` holds:
  - The state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The default WIDTH constant.
- One sub-module, the existing `fulladder` (ports A, B, Cin, sum, Cout), instantiated exactly once. No other arithmetic is allowed in this block; the counter increment is the only adder.
- Everything else is in one module: FSM, shift registers, counter, result registers.

## Test plan
- Basic add, WIDTH=8: `a`=0x5A, `b`=0x3C, `cin`=0, one-cycle `start` -> `busy` high for 8 cycles; `done` 8 cycles after the start edge; `sum`=0x96, `cout`=0.
- Full carry ripple: `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 -> `sum`=0xFF, `cout`=1.
- Ignored start: begin 0x10+0x20; pulse `start` with `a`=0xAA at cycle 3 of RUN -> result is still 0x30, `cout`=0; exactly one `done` pulse.
- Back-to-back: `start` held high with 0x01+0x01, then 0x80+0x80 presented at DONE -> first `done` gives `sum`=0x02/`cout`=0; second `done` 9 cycles later gives `sum`=0x00/`cout`=1.
- Reset mid-operation: deassert `rst_n` at RUN cycle 4 of 0x33+0x44 -> all outputs 0 immediately, state IDLE, no `done`. A new start with 0x33+0x44 then yields 0x77.
- Random check: 200 random `a`/`b`/`cin` values at WIDTH=8 and WIDTH=16, compared against a reference model of {`cout`,`sum`}.
